// File: rtl/mux_test_pkg.sv
// Shared types and the golden select function for the mux self-test sequencer.
package mux_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 8;

  // Reference behaviour of the gate network: c ? b : a
  function automatic logic golden_z(input logic a, input logic b, input logic c);
    return (a & ~c) | (c & b);
  endfunction

endpackage

// File: rtl/mux_golden_model.sv
// Combinational expected-z for the currently driven {a,b,c} vector.
module mux_golden_model
  import mux_test_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_z
);

  assign o_z = golden_z(i_a, i_b, i_c);

endmodule

// File: rtl/mux_test_sequencer.sv
// Clocked sweep of all 8 {a,b,c} vectors through the select gate network with pass/fail tally.
// Optional first-failure capture port pair is enabled by defining FAIL_CAPTURE_EN.
module mux_test_sequencer
  import mux_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             z_in,
  output logic             a_out,
  output logic             b_out,
  output logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count
`ifdef FAIL_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
`endif
);

  localparam int TMR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? TMR_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [2:0] LAST_VEC = 3'(NUM_VECTORS - 1);

  state_t            r_state;
  logic [2:0]        r_vec;
  logic [TMR_W-1:0]  r_timer;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [CNT_W-1:0]  r_pass_cnt;
  logic [CNT_W-1:0]  r_fail_cnt;
`ifdef FAIL_CAPTURE_EN
  logic              r_fail_valid;
  logic [2:0]        r_fail_vec;
`endif

  logic              w_expected;
  logic              w_match;
  logic [CNT_W-1:0]  w_pass_inc;
  logic [CNT_W-1:0]  w_fail_inc;

  mux_golden_model u_golden (
    .i_a (r_vec[2]),
    .i_b (r_vec[1]),
    .i_c (r_vec[0]),
    .o_z (w_expected)
  );

  // Case equality so an X/Z from the network counts as a mismatch
  assign w_match    = (z_in === w_expected);
  assign w_pass_inc = (r_pass_cnt == '1) ? r_pass_cnt : r_pass_cnt + CNT_W'(1);
  assign w_fail_inc = (r_fail_cnt == '1) ? r_fail_cnt : r_fail_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_timer    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
`ifdef FAIL_CAPTURE_EN
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= APPLY;
            r_vec      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
`ifdef FAIL_CAPTURE_EN
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
`endif
          end
        end
        APPLY: begin
          if (SETTLE_CYCLES > 0) begin
            r_state <= SETTLE;
            r_timer <= SETTLE_LOAD;
          end else begin
            r_state <= CHECK;
          end
        end
        SETTLE: begin
          if (r_timer == '0) begin
            r_state <= CHECK;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        CHECK: begin
          if (w_match) begin
            r_pass_cnt <= w_pass_inc;
          end else begin
            r_fail_cnt <= w_fail_inc;
          end
`ifdef FAIL_CAPTURE_EN
          if (!w_match && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_vec   <= r_vec;
          end
`endif
          if (r_vec == LAST_VEC) begin
            // Vector stays on the outputs through DONE
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_match && (r_fail_cnt == '0);
          end else begin
            r_vec   <= r_vec + 3'd1;
            r_state <= APPLY;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_out      = r_vec[2];
  assign b_out      = r_vec[1];
  assign c_out      = r_vec[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign pass_count = r_pass_cnt;
  assign fail_count = r_fail_cnt;
`ifdef FAIL_CAPTURE_EN
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;
`endif

endmodule

// File: tb/tb_mux_test_sequencer.sv
// Randomized sweep bench: two sequencers (settle 1 and settle 0) against a fault-injected select network.
module tb_mux_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] zmode = 2'd0;
  logic [7:0] rmask = 8'd0;

  logic       z1, a1, b1, c1, busy1, done1, pass1;
  logic [3:0] pc1, fc1;
  logic       z0, a0, b0, c0, busy0, done0, pass0;
  logic [3:0] pc0, fc0;
`ifdef FAIL_CAPTURE_EN
  logic       fv1, fv0;
  logic [2:0] fvec1, fvec0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Select function from first principles: bit0=c, bit1=b, bit2=a
  function automatic logic ref_z(input int v);
    return ((v & 1) != 0) ? logic'((v >> 1) & 1) : logic'((v >> 2) & 1);
  endfunction

  // Network under test: 0 correct, 1 stuck-at-0, 2 inverted, 3 random per-vector value
  function automatic logic net_z(input logic [1:0] m, input logic [7:0] rm, input logic [2:0] v);
    case (m)
      2'd0:    return ref_z(int'(v));
      2'd1:    return 1'b0;
      2'd2:    return !ref_z(int'(v));
      default: return rm[v];
    endcase
  endfunction

  always_comb z1 = net_z(zmode, rmask, {a1, b1, c1});
  always_comb z0 = net_z(zmode, rmask, {a0, b0, c0});

  mux_test_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut_s1 (
    .clk(clk), .reset(reset), .start(start), .z_in(z1),
    .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1), .pass(pass1),
    .pass_count(pc1), .fail_count(fc1)
`ifdef FAIL_CAPTURE_EN
    , .fail_valid(fv1), .fail_vec(fvec1)
`endif
  );

  mux_test_sequencer #(.SETTLE_CYCLES(0), .CNT_W(4)) u_dut_s0 (
    .clk(clk), .reset(reset), .start(start), .z_in(z0),
    .a_out(a0), .b_out(b0), .c_out(c0), .busy(busy0), .done(done0), .pass(pass0),
    .pass_count(pc0), .fail_count(fc0)
`ifdef FAIL_CAPTURE_EN
    , .fail_valid(fv0), .fail_vec(fvec0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input logic [1:0] mode, input bit mid_start);
    int exp_fail;
    int first_fail;
    int lat1;
    int lat0;
    int cyc;
    int mid_at;
    int seq_err1;
    int seq_err0;
    logic [2:0] seq1[$];
    logic [2:0] seq0[$];
    exp_fail   = 0;
    first_fail = -1;
    zmode = mode;
    rmask = 8'($urandom);
    for (int v = 0; v < 8; v++) begin
      if (net_z(mode, rmask, 3'(v)) != ref_z(v)) begin
        exp_fail++;
        if (first_fail < 0) first_fail = v;
      end
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise_s1", busy1, 1);
    check("busy_rise_s0", busy0, 1);
    check("done_clr", done1, 0);
    check("cnt_clr", {pc1, fc1, pc0, fc0}, 0);

    cyc    = 1;
    lat1   = -1;
    lat0   = -1;
    mid_at = $urandom_range(2, 12);
    while ((lat1 < 0 || lat0 < 0) && cyc < 60) begin
      if (busy1) seq1.push_back({a1, b1, c1});
      if (busy0) seq0.push_back({a0, b0, c0});
      if (mid_start && cyc == mid_at) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
      if (done1 && lat1 < 0) lat1 = cyc;
      if (done0 && lat0 < 0) lat0 = cyc;
    end
    check("latency_s1", 32'(lat1), 25);
    check("latency_s0", 32'(lat0), 17);

    seq_err1 = (seq1.size() != 24) ? 1 : 0;
    foreach (seq1[i]) if (seq1[i] != 3'(i / 3)) seq_err1++;
    seq_err0 = (seq0.size() != 16) ? 1 : 0;
    foreach (seq0[i]) if (seq0[i] != 3'(i / 2)) seq_err0++;
    check("vec_seq_s1", 32'(seq_err1), 0);
    check("vec_seq_s0", 32'(seq_err0), 0);

    check("fail_cnt_s1", fc1, 32'(exp_fail));
    check("pass_cnt_s1", pc1, 32'(8 - exp_fail));
    check("pass_s1", pass1, (exp_fail == 0) ? 1 : 0);
    check("fail_cnt_s0", fc0, 32'(exp_fail));
    check("pass_cnt_s0", pc0, 32'(8 - exp_fail));
    check("pass_s0", pass0, (exp_fail == 0) ? 1 : 0);
`ifdef FAIL_CAPTURE_EN
    check("fail_valid", fv1, (exp_fail > 0) ? 1 : 0);
    if (exp_fail > 0) check("fail_vec", fvec1, 32'(first_fail));
`endif
    tick();
    tick();
    check("done_hold", {done1, done0}, 2'b11);
    check("vec_hold", {a1, b1, c1, a0, b0, c0}, 6'b111111);
    $display("sweep mode=%0d mid_start=%0d mask=%02h lat=%0d/%0d pass=%0d fail=%0d exp_fail=%0d",
             mode, mid_start, rmask, lat1, lat0, pc1, fc1, exp_fail);
  endtask

  task automatic reset_mid_sweep();
    zmode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    // 15 cycles in: settle-1 instance is in CHECK of vector 4
    check("at_vec4", {busy1, a1, b1, c1}, 4'b1100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", {busy1, busy0}, 0);
    check("rst_done", {done1, done0, pass1, pass0}, 0);
    check("rst_cnt", {pc1, fc1, pc0, fc0}, 0);
    check("rst_vec", {a1, b1, c1, a0, b0, c0}, 0);
    for (int i = 0; i < 30; i++) tick();
    check("rst_stays_idle", {busy1, busy0, done1, done0}, 0);
    $display("reset mid-sweep: busy=%0d done=%0d pc=%0d fc=%0d", busy1, done1, pc1, fc1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_flags", {busy1, done1, pass1, busy0, done0, pass0}, 0);
    check("reset_cnt", {pc1, fc1, pc0, fc0}, 0);
    check("reset_vec", {a1, b1, c1, a0, b0, c0}, 0);
    $display("reset: busy=%0d done=%0d vec=%0d%0d%0d", busy1, done1, a1, b1, c1);

    run_sweep(2'd0, 1'b0);
    run_sweep(2'd1, 1'b1);
    run_sweep(2'd2, 1'b0);
    for (int k = 0; k < 4; k++) run_sweep(2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    reset_mid_sweep();
    run_sweep(2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
